// File: rtl/mp_adc_unit_if.sv
// ============================================================================
// Module   : mp_adc_unit_if
// Purpose  : Start/done handshake, operand and flag bundle for mp_adc_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mp_adc_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LIMBS      = 2
);
  localparam int W = DATA_WIDTH * LIMBS;

  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] result_o;
  logic         busy_o;
  logic         done_o;
  logic         flag_carry_o;
  logic         flag_zero_o;
  logic         flag_negative_o;
  logic         flag_overflow_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  result_o, busy_o, done_o,
    input  flag_carry_o, flag_zero_o, flag_negative_o, flag_overflow_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output result_o, busy_o, done_o,
    output flag_carry_o, flag_zero_o, flag_negative_o, flag_overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/mp_adc_unit.sv
// ============================================================================
// Module   : mp_adc_unit
// Purpose  : Limb-serial multi-precision ALU with persistent C/Z/N(/V) flags.
//            Optional registered overflow flag: define MP_ADC_OVERFLOW_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mp_adc_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LIMBS      = 2
) (
  input  wire logic    clk,
  input  wire logic    reset,
  mp_adc_unit_if.slave bus
);

  localparam int c_W    = DATA_WIDTH * LIMBS;
  localparam int c_IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(LIMBS - 1);
  localparam logic [c_IDXW-1:0] c_ONE  = c_IDXW'(1);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_ADC = 3'b001;
  localparam logic [2:0] c_OP_SUB = 3'b010;
  localparam logic [2:0] c_OP_SBC = 3'b011;
  localparam logic [2:0] c_OP_AND = 3'b100;
  localparam logic [2:0] c_OP_OR  = 3'b101;
  localparam logic [2:0] c_OP_XOR = 3'b110;
  localparam logic [2:0] c_OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_op;
  logic [c_W-1:0]      r_a;
  logic [c_W-1:0]      r_b;
  logic [c_IDXW-1:0]   r_idx;
  logic [c_W-1:0]      r_shadow;
  logic                r_shadow_c;
  logic [c_W-1:0]      r_result;
  logic                r_c;
  logic                r_z;
  logic                r_n;
  logic                r_done;

  logic                  w_is_sub;
  logic                  w_is_logic;
  logic                  w_cin0;
  logic                  w_cin;
  logic [DATA_WIDTH-1:0] w_a_limb;
  logic [DATA_WIDTH-1:0] w_b_limb;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_limb_res;
  logic [c_W-1:0]        w_shadow_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_state_next = S_EXEC;
      S_EXEC:  if (r_idx == c_LAST) w_state_next = S_LATCH;
      S_LATCH: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operands shift right one limb per EXEC cycle, so the low limb is always current.
  always_comb begin
    w_a_limb   = r_a[DATA_WIDTH-1:0];
    w_b_limb   = r_b[DATA_WIDTH-1:0];
    w_is_sub   = (r_op == c_OP_SUB) || (r_op == c_OP_SBC) || (r_op == c_OP_CMP);
    w_is_logic = r_op[2] && (r_op != c_OP_CMP);
    w_b_eff    = w_is_sub ? ~w_b_limb : w_b_limb;
    case (r_op)
      c_OP_ADD: w_cin0 = 1'b0;
      c_OP_ADC: w_cin0 = r_c;
      c_OP_SUB: w_cin0 = 1'b1;
      c_OP_SBC: w_cin0 = r_c;
      c_OP_CMP: w_cin0 = 1'b1;
      default:  w_cin0 = 1'b0;
    endcase
    w_cin = (r_idx == '0) ? w_cin0 : r_shadow_c;
    w_sum = {1'b0, w_a_limb} + {1'b0, w_b_eff} + {{DATA_WIDTH{1'b0}}, w_cin};
    case (r_op)
      c_OP_AND: w_limb_res = w_a_limb & w_b_limb;
      c_OP_OR:  w_limb_res = w_a_limb | w_b_limb;
      c_OP_XOR: w_limb_res = w_a_limb ^ w_b_limb;
      default:  w_limb_res = w_sum[DATA_WIDTH-1:0];
    endcase
    // New limb enters at the top; after LIMBS cycles the limbs sit in order.
    w_shadow_next = (r_shadow >> DATA_WIDTH)
                  | (c_W'(w_limb_res) << (c_W - DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_shadow_c <= 1'b0;
      r_result   <= '0;
      r_c        <= 1'b0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_op  <= bus.op_i;
            r_a   <= bus.a_i;
            r_b   <= bus.b_i;
            r_idx <= '0;
          end
        end
        S_EXEC: begin
          r_shadow   <= w_shadow_next;
          r_shadow_c <= w_sum[DATA_WIDTH];
          r_a        <= r_a >> DATA_WIDTH;
          r_b        <= r_b >> DATA_WIDTH;
          r_idx      <= r_idx + c_ONE;
        end
        S_LATCH: begin
          if (r_op != c_OP_CMP) r_result <= r_shadow;
          if (!w_is_logic)      r_c      <= r_shadow_c;
          r_z    <= (r_shadow == '0);
          r_n    <= r_shadow[c_W-1];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MP_ADC_OVERFLOW_EN
  logic r_shadow_v;
  logic r_v;
  logic w_v_limb;

  // Only the value from the top limb survives into LATCH, which is the signed one.
  assign w_v_limb = (w_a_limb[DATA_WIDTH-1] == w_b_eff[DATA_WIDTH-1])
                 && (w_sum[DATA_WIDTH-1] != w_a_limb[DATA_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_v <= 1'b0;
      r_v        <= 1'b0;
    end else begin
      if (r_state == S_EXEC)  r_shadow_v <= w_v_limb;
      if (r_state == S_LATCH) r_v        <= w_is_logic ? 1'b0 : r_shadow_v;
    end
  end

  assign bus.flag_overflow_o = r_v;
`else
  assign bus.flag_overflow_o = 1'b0;
`endif

  assign bus.result_o        = r_result;
  assign bus.busy_o          = (r_state != S_IDLE);
  assign bus.done_o          = r_done;
  assign bus.flag_carry_o    = r_c;
  assign bus.flag_zero_o     = r_z;
  assign bus.flag_negative_o = r_n;

endmodule

`default_nettype wire

// File: tb/tb_mp_adc_unit.sv
// ============================================================================
// Module   : tb_mp_adc_unit
// Purpose  : Directed checks of mp_adc_unit at LIMBS=2 and LIMBS=1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mp_adc_unit;

  localparam int c_DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mp_adc_unit_if #(.DATA_WIDTH(c_DW), .LIMBS(2)) bus2 ();
  mp_adc_unit_if #(.DATA_WIDTH(c_DW), .LIMBS(1)) bus1 ();

  mp_adc_unit #(.DATA_WIDTH(c_DW), .LIMBS(2)) u_dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2.slave)
  );

  mp_adc_unit #(.DATA_WIDTH(c_DW), .LIMBS(1)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ev(input logic v);
`ifdef MP_ADC_OVERFLOW_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  function automatic logic [3:0] flags2();
    return {bus2.flag_carry_o, bus2.flag_zero_o, bus2.flag_negative_o, bus2.flag_overflow_o};
  endfunction

  // Issues one op on the LIMBS=2 unit; returns edges from start to done (-1 on timeout).
  task automatic run2(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      output int lat, output int busy_n);
    bus2.op_i    = op;
    bus2.a_i     = a;
    bus2.b_i     = b;
    bus2.start_i = 1'b1;
    @(posedge clk); #1;
    bus2.start_i = 1'b0;
    bus2.a_i     = ~a;
    bus2.b_i     = ~b;
    lat    = -1;
    busy_n = int'(bus2.busy_o);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (bus2.busy_o) busy_n++;
      if (bus2.done_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    bus1.op_i    = op;
    bus1.a_i     = a;
    bus1.b_i     = b;
    bus1.start_i = 1'b1;
    @(posedge clk); #1;
    bus1.start_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (bus1.done_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check2(input string tag, input logic [15:0] res, input logic [3:0] cznv);
    check({tag, "_res"}, 32'(bus2.result_o), 32'(res));
    check({tag, "_cznv"}, 32'(flags2()), 32'(cznv));
  endtask

  int lat;
  int bn;
  int dn;

  initial begin
    rst          = 1'b1;
    bus2.start_i = 1'b0; bus2.op_i = '0; bus2.a_i = '0; bus2.b_i = '0;
    bus1.start_i = 1'b0; bus1.op_i = '0; bus1.a_i = '0; bus1.b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check2("reset", 16'h0000, 4'b0000);
    check("reset_busy", 32'(bus2.busy_o), 32'd0);
    check("reset_done", 32'(bus2.done_o), 32'd0);
    check("reset1_res", 32'(bus1.result_o), 32'd0);

    // LIMBS=1
    run1(3'b000, 8'hFF, 8'h01, lat);
    check("l1_add_lat", 32'(lat), 32'd2);
    check("l1_add_res", 32'(bus1.result_o), 32'h00);
    check("l1_add_czn", 32'({bus1.flag_carry_o, bus1.flag_zero_o, bus1.flag_negative_o}), 32'b110);
    run1(3'b001, 8'h00, 8'h05, lat);
    check("l1_adc_res", 32'(bus1.result_o), 32'h06);
    check("l1_adc_czn", 32'({bus1.flag_carry_o, bus1.flag_zero_o, bus1.flag_negative_o}), 32'b000);

    // LIMBS=2 arithmetic, compare and logic
    run2(3'b000, 16'h00FF, 16'h0001, lat, bn);
    check("add_lat", 32'(lat), 32'd3);
    check("add_busy_cycles", 32'(bn), 32'd3);
    check2("add", 16'h0100, 4'b0000);
    run2(3'b010, 16'h0000, 16'h0001, lat, bn);
    check2("sub", 16'hFFFF, {3'b001, ev(1'b0)});
    run2(3'b111, 16'h1234, 16'h1234, lat, bn);
    check2("cmp", 16'hFFFF, {3'b110, ev(1'b0)});
    run2(3'b100, 16'hF0F0, 16'h0FF0, lat, bn);
    check2("and", 16'h00F0, 4'b1000);
    run2(3'b000, 16'h7FFF, 16'h0001, lat, bn);
    check2("add_ovf", 16'h8000, {3'b001, ev(1'b1)});
    run2(3'b010, 16'h8000, 16'h0001, lat, bn);
    check2("sub_ovf", 16'h7FFF, {3'b100, ev(1'b1)});

    // start held high through an op: only the first one commits
    bus2.op_i = 3'b000; bus2.a_i = 16'h0001; bus2.b_i = 16'h0001; bus2.start_i = 1'b1;
    @(posedge clk); #1;
    bus2.op_i = 3'b010; bus2.a_i = 16'h1111; bus2.b_i = 16'h2222;
    dn = 0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (bus2.done_o) dn++;
    end
    check("hammer_done_cnt", 32'(dn), 32'd1);
    check("hammer_res", 32'(bus2.result_o), 32'h0002);
    bus2.op_i = 3'b000;
    @(posedge clk); #1;
    bus2.start_i = 1'b0;
    check("b2b_accept_busy", 32'(bus2.busy_o), 32'd1);
    dn = 0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (bus2.done_o) dn++;
    end
    check("b2b_done_cnt", 32'(dn), 32'd1);
    check2("b2b", 16'h3333, 4'b0000);

    // carry chaining across instructions, issued in the done cycle
    run2(3'b000, 16'hFFFF, 16'h0001, lat, bn);
    check2("wrap", 16'h0000, 4'b1100);
    run2(3'b001, 16'h00FF, 16'h0000, lat, bn);
    check2("adc_chain", 16'h0100, 4'b0000);
    run2(3'b010, 16'h0005, 16'h0003, lat, bn);
    check2("sub_small", 16'h0002, 4'b1000);

    // reset in the middle of EXEC
    bus2.op_i = 3'b000; bus2.a_i = 16'h00FF; bus2.b_i = 16'h0001; bus2.start_i = 1'b1;
    @(posedge clk); #1;
    bus2.start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check2("abort", 16'h0000, 4'b0000);
    check("abort_busy", 32'(bus2.busy_o), 32'd0);
    dn = int'(bus2.done_o);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      if (bus2.done_o) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run2(3'b001, 16'h0001, 16'h0001, lat, bn);
    check("post_abort_lat", 32'(lat), 32'd3);
    check2("post_abort_adc", 16'h0002, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mp_adc_unit.md
# mp_adc_unit

Multi-precision arithmetic/logic unit with a registered flag file, for the SAP-2 CPU datapath. It generalises the 8-bit ADD/ADC/SUB path to operands of `LIMBS × DATA_WIDTH` bits. Operands are processed one limb per cycle, least significant limb first, with the carry chained between limbs. Flags persist across operations, so ADC/SBC chains span instructions exactly as the CPU's A-register ops do. A start/done handshake lets the control unit stall its microstep counter while the unit is busy.

## Interface
Parameters:
- `DATA_WIDTH`, 8: limb width in bits.
- `LIMBS`, 2: limbs per operand, ≥1. Full width is `W = DATA_WIDTH*LIMBS`.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_i`  in  1  request an operation; sampled only in IDLE.
- `op_i`  in  3  opcode, captured with `start_i`.
- `a_i`  in  W  operand A, captured with `start_i`.
- `b_i`  in  W  operand B, captured with `start_i`.
- `result_o`  out  W  committed result.
- `busy_o`  out  1  operation in flight.
- `done_o`  out  1  one-cycle pulse when the result and flags commit.
- `flag_carry_o`  out  1  carry flag.
- `flag_zero_o`  out  1  zero flag.
- `flag_negative_o`  out  1  negative flag.
- `flag_overflow_o`  out  1  signed overflow flag; see Configuration.

## Operation
- Opcodes:
  - 000 ADD: cin = 0.
  - 001 ADC: cin = C.
  - 010 SUB: A + ~B, cin = 1.
  - 011 SBC: A + ~B, cin = C.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 CMP: computed as SUB; updates flags only and leaves `result_o` unchanged.
- Subtraction carry convention: C = 1 means no borrow.
- Carry out of limb k is the carry in of limb k+1. C after the operation is the carry out of the top limb.
- Z = 1 when the full W-bit computed value is zero. It is evaluated over all limbs, not only the last one.
- N = bit W-1 of the computed value.
- Logic ops leave C unchanged and clear V.
- State machine:
  - IDLE: on `start_i`=1, capture `op_i`, `a_i` and `b_i`, clear limb index, go to EXEC. `start_i`=0 stays in IDLE.
  - EXEC: each cycle computes limb `idx` into a shadow result and the shadow carry. After limb LIMBS-1, go to LATCH.
  - LATCH: commit shadow to `result_o` (except CMP), commit flags, pulse `done_o`, go to IDLE.
- `start_i` while not in IDLE is ignored; it is neither queued nor able to corrupt captured operands.
- Input changes after capture have no effect on the operation in flight.
- `result_o` and the flags hold their values between operations.

## Timing
- Reset: `result_o`=0, all flags 0, `busy_o`=0, `done_o`=0, state IDLE, shadow registers cleared.
- Reset asserted mid-operation aborts it on that edge. No commit occurs and no `done_o` pulse is produced.
- `start_i` sampled at edge 0:
  - `busy_o`=1 after edge 0.
  - Limbs are computed at edges 1..LIMBS.
  - Commit happens at edge LIMBS+1; after that edge `busy_o`=0 and `done_o`=1 for exactly one cycle.
- Latency from start to committed outputs is LIMBS+1 cycles.
- A new `start_i` is accepted at edge LIMBS+2, during the `done_o` cycle. The back-to-back issue period is LIMBS+2 cycles.
- ADC/SBC launched in the `done_o` cycle see the C just committed.
- `LIMBS`=1: EXEC lasts one cycle and latency is 2.

## Configuration
- `MP_ADC_OVERFLOW_EN` defined:
  - `flag_overflow_o` is a registered V flag, committed in LATCH.
  - For arithmetic ops and CMP, V = (sign A == sign of effective B) && (sign result != sign A). Effective B is ~B for subtraction ops.
  - V is cleared by logic ops and by reset.
- Not defined: no V register is built and `flag_overflow_o` is tied to 0.

## Test plan
- LIMBS=1: ADD 0xFF+0x01 -> result 0x00, C=1, Z=1, N=0, `done_o` 2 cycles after start. Then ADC 0x00+0x05 -> result 0x06, C=0, Z=0, N=0.
- LIMBS=2: ADD 0x00FF+0x0001 -> 0x0100, C=0, Z=0, N=0. `busy_o` high for exactly 3 cycles, `done_o` asserted the cycle after the commit edge. SUB 0x0000−0x0001 -> 0xFFFF, C=0, N=1, Z=0.
- LIMBS=2, CMP 0x1234 vs 0x1234 with `result_o`=0xFFFF beforehand -> Z=1, C=1, `result_o` stays 0xFFFF. Then AND 0xF0F0&0x0FF0 -> 0x00F0, C stays 1.
- With `MP_ADC_OVERFLOW_EN`: ADD 0x7FFF+0x0001 -> 0x8000, V=1, N=1. SUB 0x8000−0x0001 -> 0x7FFF, V=1. Without the macro, `flag_overflow_o` stays 0 for both.
- Assert `start_i` every cycle during an op with different operands -> only the first op commits, with a single `done_o`. The next start is accepted in the `done_o` cycle.
- Reset asserted during EXEC of ADD 0x00FF+0x0001 -> all outputs 0, no `done_o`. The following ADC 0x0001+0x0001 yields 0x0002, because C was cleared by reset.
